// File: rtl/median_stream_pkg.sv
// ----------------------------------------------------------------------------
// median_stream_pkg
// Shared types for the streaming 10-sample sort/median block.
//   data_t  : 32-bit unsigned sample
//   N_DEF   : default frame length
//   state_e : control states (LOAD -> SORT -> DRAIN -> LOAD)
// ----------------------------------------------------------------------------
package median_stream_pkg;

   typedef logic [31:0] data_t;

   localparam int N_DEF = 10;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/median_stream_10_cas.sv
// ----------------------------------------------------------------------------
// sort_cas
// Combinational compare-exchange cell for the odd-even transposition sort.
// Ports:
//   a, b   : input pair, a is the lower-index element
//   lo, hi : ordered pair (lo <= hi), unsigned compare
// ----------------------------------------------------------------------------
module sort_cas #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);

   // Strict '>' leaves equal values where they are, so ties never swap.
   always_comb begin
      if (a > b) begin
         lo = b;
         hi = a;
      end else begin
         lo = a;
         hi = b;
      end
   end

endmodule

// File: rtl/median_stream_10.sv
// ----------------------------------------------------------------------------
// median_stream_10
// Collects N unsorted samples per frame (valid/ready in), sorts the frame in
// place with odd-even transposition (one phase per clock), then streams it out
// ascending (valid/ready out, out_last on the largest). The lower median
// (sorted element N/2-1) is held on med_data until the next frame replaces it.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready     : input handshake, in_data = unsorted sample
//   out_valid/out_ready   : output handshake, out_data = sorted sample
//   out_last              : final (largest) sample of the frame
//   med_valid, med_data   : lower median of the most recent sorted frame
//
// Build option:
//   MEDIAN_STREAM_EARLY_EXIT_EN - leave SORT at the end of an odd phase when
//   that phase and the even phase before it made no swaps. Output data is the
//   same either way; only the sort latency changes.
// ----------------------------------------------------------------------------
module median_stream_10
   import median_stream_pkg::*;
#(
   parameter int N = N_DEF,          // frame length, even and >= 2
   parameter int W = $bits(data_t)   // sample width
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         med_valid,
   output logic [W-1:0] med_data
);

   localparam int            CW   = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam int            MED  = N / 2 - 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] phase_q;
   logic          rdy_q;
   logic [W-1:0]  med_q;
   logic          med_valid_q;

   logic [W-1:0]  buf_q  [N];
   logic [W-1:0]  sort_d [N];
   logic [W-1:0]  cas_lo [N-1];
   logic [W-1:0]  cas_hi [N-1];

   logic          in_fire;
   logic          out_fire;
   logic          sort_done;

   // in_ready comes from a flop so it stays low during reset and rises on the
   // first clock after release.
   assign in_ready  = rdy_q;
   assign in_fire   = in_valid && rdy_q;
   assign out_valid = (state_q == DRAIN);
   assign out_fire  = out_valid && out_ready;
   assign out_data  = out_valid ? buf_q[cnt_q] : '0;
   assign out_last  = out_valid && (cnt_q == LAST);
   assign med_valid = med_valid_q;
   assign med_data  = med_q;

   // One cell per adjacent pair; the phase parity picks which cells write back.
   for (genvar i = 0; i < N - 1; i++) begin : g_cas
      sort_cas #(.W(W)) u_cas (
         .a  (buf_q[i]),
         .b  (buf_q[i+1]),
         .lo (cas_lo[i]),
         .hi (cas_hi[i])
      );
   end

   // Even phase: pairs (0,1),(2,3)...; odd phase: pairs (1,2),(3,4)...
   // Active pairs are disjoint, so the write-backs never overlap.
   always_comb begin
      sort_d = buf_q;
      for (int i = 0; i < N - 1; i++) begin
         if (i[0] == phase_q[0]) begin
            sort_d[i]   = cas_lo[i];
            sort_d[i+1] = cas_hi[i];
         end
      end
   end

`ifdef MEDIAN_STREAM_EARLY_EXIT_EN
   logic phase_swap;
   logic even_swap_q;

   // A cell swapped exactly when its low output differs from its a input.
   always_comb begin
      phase_swap = 1'b0;
      for (int i = 0; i < N - 1; i++) begin
         if (i[0] == phase_q[0] && cas_lo[i] != buf_q[i]) phase_swap = 1'b1;
      end
   end

   // A clean even phase followed by a clean odd phase checks every adjacent
   // pair, so the frame is already in order.
   assign sort_done = (phase_q == LAST) ||
                      (phase_q[0] && !phase_swap && !even_swap_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         even_swap_q <= 1'b0;
      end else if (state_q == SORT && !phase_q[0]) begin
         even_swap_q <= phase_swap;
      end
   end
`else
   assign sort_done = (phase_q == LAST);
`endif

   // NOTE: every combinational output gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (in_fire && cnt_q == LAST)  state_d = SORT;
         SORT:    if (sort_done)                 state_d = DRAIN;
         DRAIN:   if (out_fire && cnt_q == LAST) state_d = LOAD;
         default:                                state_d = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block or statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         phase_q     <= '0;
         rdy_q       <= 1'b0;
         med_q       <= '0;
         med_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d == LOAD);
         case (state_q)
            LOAD: begin
               if (in_fire) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
            SORT: begin
               phase_q <= sort_done ? '0 : phase_q + CW'(1);
               if (sort_done) begin
                  // Median taken from the post-phase values of this last phase.
                  med_q       <= sort_d[MED];
                  med_valid_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (out_fire) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: the sample array is deliberately not reset: every entry is written
   // during LOAD before it is ever sorted or read, and a reset would only add
   // N x W reset nets for nothing.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         buf_q[cnt_q] <= in_data;
      end else if (state_q == SORT) begin
         buf_q <= sort_d;
      end
   end

endmodule
